// File: rtl/run_mon_pkg.sv
// Shared definitions for the run monitor: FSM state encoding and a
// constant-foldable ceil(log2) used to size index and count fields.
package run_mon_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Smallest r such that 2**r >= value; clog2(1) returns 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/run_mon_table.sv
// Generic DEPTH x DATA_W register file: one synchronous write port, one
// asynchronous read port. Contents are not reset.
module run_mon_table
  import run_mon_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the write data on the rising edge when the strobe is high.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dut_run_monitor.sv
// Run monitor: holds the processor in reset, then compares its output
// stream against a loadable expected table and reports the verdict.
// Optional macro RUN_MON_TRACE_EN adds a capture RAM plus trace read port.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | no run yet; processor held in reset
// S_RESET | processor reset held for RST_CYCLES cycles
// S_RUN   | processor released; valid samples compared in order
// S_DONE  | verdict frozen; processor held in reset until next start
module dut_run_monitor
  import run_mon_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int RST_CYCLES = 5,
  parameter int TIMEOUT    = 255,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              exp_we,
  input  logic [AW-1:0]     exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] dout,
  input  logic              dout_vld,
`ifdef RUN_MON_TRACE_EN
  input  logic [AW-1:0]     trace_addr,
  output logic [DATA_W-1:0] trace_data,
`endif
  output logic              dut_rst,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [AW:0]       err_cnt,
  output logic [AW-1:0]     first_err_idx
);

  localparam int HW = clog2(RST_CYCLES) + 1;
  localparam int TW = clog2(TIMEOUT) + 1;
  localparam logic [AW:0]   ERR_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_LD  = TW'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [AW-1:0]     idx, idx_nx;
  logic [HW-1:0]     hold, hold_nx;
  logic [TW-1:0]     idle, idle_nx;
  logic [AW:0]       err_nx;
  logic [AW-1:0]     ferr_nx;
  logic              done_nx, timeout_nx;
  logic [DATA_W-1:0] exp_rd;

  run_mon_table #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_exp_table (
    .clk   (clk),
    .we    (exp_we),
    .waddr (exp_addr),
    .wdata (exp_data),
    .raddr (idx),
    .rdata (exp_rd)
  );

  // Next-state and next-value logic; hold and idle timers are down-counters
  // that act on reaching zero.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    hold_nx    = hold;
    idle_nx    = idle;
    err_nx     = err_cnt;
    ferr_nx    = first_err_idx;
    done_nx    = done;
    timeout_nx = timeout;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx   = S_RESET;
          idx_nx     = '0;
          hold_nx    = HOLD_LD;
          idle_nx    = '0;
          err_nx     = '0;
          ferr_nx    = '0;
          done_nx    = 1'b0;
          timeout_nx = 1'b0;
        end
      end
      S_RESET: begin
        if (hold == '0) begin
          state_nx = S_RUN;
          idle_nx  = IDLE_LD;
        end else begin
          hold_nx = hold - 1'b1;
        end
      end
      S_RUN: begin
        if (dout_vld) begin
          if (dout != exp_rd) begin
            if (err_cnt == '0) ferr_nx = idx;
            if (err_cnt != ERR_MAX) err_nx = err_cnt + 1'b1;
          end
          idle_nx = IDLE_LD;
          if (idx == IDX_LAST) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end else if (idle != '0) begin
          idle_nx = idle - 1'b1;
        end
        // A sample arriving on the expiry cycle is still scored above.
        if (idle == '0) begin
          timeout_nx = 1'b1;
          state_nx   = S_DONE;
          done_nx    = 1'b1;
        end
      end
    endcase
  end

  // State register plus registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      hold          <= '0;
      idle          <= '0;
      dut_rst       <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else begin
      state         <= state_nx;
      idx           <= idx_nx;
      hold          <= hold_nx;
      idle          <= idle_nx;
      dut_rst       <= (state_nx != S_RUN);
      busy          <= (state_nx == S_RESET) || (state_nx == S_RUN);
      done          <= done_nx;
      pass          <= (state_nx == S_DONE) && (err_nx == '0) && !timeout_nx;
      timeout       <= timeout_nx;
      err_cnt       <= err_nx;
      first_err_idx <= ferr_nx;
    end
  end

`ifdef RUN_MON_TRACE_EN
  logic [DATA_W-1:0] trace_rd;

  run_mon_table #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_trace_ram (
    .clk   (clk),
    .we    ((state == S_RUN) && dout_vld),
    .waddr (idx),
    .wdata (dout),
    .raddr (trace_addr),
    .rdata (trace_rd)
  );

  // Register the capture RAM read for a one-cycle trace read latency.
  always_ff @(posedge clk) begin
    if (!rst) trace_data <= '0;
    else      trace_data <= trace_rd;
  end
`endif

endmodule

// File: tb/tb_dut_run_monitor.sv
// Self-checking bench for dut_run_monitor: vector table of whole runs,
// randomized runs scored by a run-level reference model, and hand-written
// sequences for reset, ignored inputs and trace readback.
module tb_dut_run_monitor;

  localparam int DATA_W     = 8;
  localparam int DEPTH      = 16;
  localparam int AW         = 4;
  localparam int RST_CYCLES = 5;
  localparam int TIMEOUT    = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              exp_we = 1'b0;
  logic [AW-1:0]     exp_addr = '0;
  logic [DATA_W-1:0] exp_data = '0;
  logic [DATA_W-1:0] dout = '0;
  logic              dout_vld = 1'b0;
  logic              dut_rst, busy, done, pass, timeout;
  logic [AW:0]       err_cnt;
  logic [AW-1:0]     first_err_idx;
`ifdef RUN_MON_TRACE_EN
  logic [AW-1:0]     trace_addr = '0;
  logic [DATA_W-1:0] trace_data;
`endif

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] tbl [DEPTH];
  logic [DATA_W-1:0] smp [DEPTH];
  int                gap [DEPTH];

  typedef struct {
    logic [15:0] bad_mask;
    int          gap_all;
    int          long_idx;
    int          long_gap;
    int          start_edge;
    int          x_edges;
    int          x_err;
    int          x_ferr;
    bit          x_to;
  } vec_t;

  vec_t vecs [8];

  dut_run_monitor #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .exp_we        (exp_we),
    .exp_addr      (exp_addr),
    .exp_data      (exp_data),
    .dout          (dout),
    .dout_vld      (dout_vld),
`ifdef RUN_MON_TRACE_EN
    .trace_addr    (trace_addr),
    .trace_data    (trace_data),
`endif
    .dut_rst       (dut_rst),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < DEPTH; i++) begin
      exp_we = 1'b1; exp_addr = AW'(i); exp_data = tbl[i];
      tick();
    end
    exp_we = 1'b0;
  endtask

  // Run-level model: each sample i follows gap[i] idle cycles. The idle
  // timer expires on the TIMEOUT-th cycle after the last sample (or run
  // entry); a sample landing exactly on that cycle still gets scored.
  task automatic model(output int edges, output int err, output int ferr, output bit to);
    edges = 0; err = 0; ferr = 0; to = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (gap[i] >= TIMEOUT) begin
        edges += TIMEOUT; to = 1'b1; break;
      end
      edges += gap[i] + 1;
      if (smp[i] != tbl[i]) begin
        if (err == 0) ferr = i;
        err++;
      end
      if (gap[i] == TIMEOUT - 1) begin
        to = 1'b1; break;
      end
    end
  endtask

  task automatic begin_run(input string tag);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("%s_done_clr", tag), done, 0);
    check($sformatf("%s_busy", tag), busy, 1);
    n = 0;
    while (dut_rst && n < 40) begin
      tick();
      n++;
    end
    check($sformatf("%s_rst_len", tag), n, RST_CYCLES);
  endtask

  task automatic run_seq(input string tag, input int start_edge, input int x_edges,
                         input int x_err, input int x_ferr, input bit x_to);
    int e;
    begin_run(tag);
    e = 0;
    for (int i = 0; i < DEPTH && e < x_edges; i++) begin
      for (int j = 0; j <= gap[i] && e < x_edges; j++) begin
        dout_vld = (j == gap[i]);
        dout     = (j == gap[i]) ? smp[i] : DATA_W'($urandom);
        start    = (e == start_edge);
        tick();
        e++;
        start = 1'b0;
        if (e == x_edges - 1) check($sformatf("%s_early_done", tag), done, 0);
      end
    end
    dout_vld = 1'b0;
    check($sformatf("%s_done", tag), done, 1);
    check($sformatf("%s_err", tag), err_cnt, x_err);
    check($sformatf("%s_ferr", tag), first_err_idx, x_ferr);
    check($sformatf("%s_to", tag), timeout, x_to);
    check($sformatf("%s_pass", tag), pass, (x_err == 0 && !x_to) ? 1 : 0);
    check($sformatf("%s_idle_busy", tag), busy, 0);
    check($sformatf("%s_idle_rst", tag), dut_rst, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check($sformatf("%s_dut_rst", tag), dut_rst, 1);
    check($sformatf("%s_busy", tag), busy, 0);
    check($sformatf("%s_done", tag), done, 0);
    check($sformatf("%s_pass", tag), pass, 0);
    check($sformatf("%s_to", tag), timeout, 0);
    check($sformatf("%s_err", tag), err_cnt, 0);
    check($sformatf("%s_ferr", tag), first_err_idx, 0);
  endtask

  task automatic clean_stim();
    for (int i = 0; i < DEPTH; i++) begin
      tbl[i] = DATA_W'(i + 1); smp[i] = tbl[i]; gap[i] = 0;
    end
  endtask

  initial begin
    int m_edges, m_err, m_ferr;
    bit m_to;

    //          mask      gap lidx lgap  st  edges err ferr to
    vecs[0] = '{16'h0000, 0,  -1,  0,   -1, 16,   0,  0,   0};
    vecs[1] = '{16'h0208, 0,  -1,  0,   -1, 16,   2,  3,   0};
    vecs[2] = '{16'h0000, 0,   4,  255, -1, 259,  0,  0,   1};
    vecs[3] = '{16'hFFFF, 0,  -1,  0,   -1, 16,   16, 0,   0};
    vecs[4] = '{16'h0001, 0,   0,  254, -1, 255,  1,  0,   1};
    vecs[5] = '{16'h8000, 1,  -1,  0,   -1, 32,   1,  15,  0};
    vecs[6] = '{16'h0000, 0,  -1,  0,   5,  16,   0,  0,   0};
    vecs[7] = '{16'h0000, 0,   8,  253, -1, 269,  0,  0,   0};

    rst = 1'b0;
    tick(); tick();
    check_reset_vals("por");
    rst = 1'b1;
    tick();

    // samples presented while idle must not be scored
    clean_stim();
    load_table();
    dout_vld = 1'b1; dout = 8'hFF;
    repeat (3) tick();
    dout_vld = 1'b0;
    check_reset_vals("idle_vld");

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] = DATA_W'(i + 1);
        smp[i] = vecs[v].bad_mask[i] ? 8'hFF : tbl[i];
        gap[i] = (i == vecs[v].long_idx) ? vecs[v].long_gap : vecs[v].gap_all;
      end
      load_table();
      run_seq($sformatf("vec%0d", v), vecs[v].start_edge, vecs[v].x_edges,
              vecs[v].x_err, vecs[v].x_ferr, vecs[v].x_to);
    end

    // reset in the middle of a run returns everything to reset values
    clean_stim();
    smp[2] = 8'hFF;
    begin_run("midrst");
    for (int i = 0; i < 7; i++) begin
      dout_vld = 1'b1; dout = smp[i];
      tick();
    end
    dout_vld = 1'b0;
    check("midrst_err_before", err_cnt, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_reset_vals("midrst");
    smp[2] = tbl[2];
    run_seq("after_rst", -1, 16, 0, 0, 1'b0);

`ifdef RUN_MON_TRACE_EN
    for (int i = 0; i < DEPTH; i++) smp[i] = DATA_W'($urandom);
    run_seq("trace_run", -1, 16, 0, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      trace_addr = AW'(i);
      tick();
      check($sformatf("trace%0d", i), trace_data, smp[i]);
    end
`endif

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] = DATA_W'($urandom_range(0, 255));
        gap[i] = $urandom_range(0, 2);
        smp[i] = ($urandom_range(0, 7) == 0) ? (tbl[i] ^ DATA_W'($urandom_range(1, 255))) : tbl[i];
      end
      if (r % 3 == 2) gap[$urandom_range(0, DEPTH - 1)] = TIMEOUT - 2 + $urandom_range(0, 3);
      load_table();
      model(m_edges, m_err, m_ferr, m_to);
      run_seq($sformatf("rnd%0d", r), -1, m_edges, m_err, m_ferr, m_to);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dut_run_monitor.md
Name: dut_run_monitor

Overview:
- Synthesizable on-chip successor to the processor bring-up bench.
- Sequences the processor-under-test's reset, then watches its data-output stream and compares each valid sample against a loadable expected-value table.
- Reports pass/fail, a mismatch count and timeout status.
- Sits between the top-level clock/reset and the processor core, with status routed to LEDs or debug pins.

Parameters:
- DATA_W, 8, width of processor output and expected entries
- DEPTH, 16, number of expected samples per run (power of 2, >=2)
- RST_CYCLES, 5, cycles the DUT reset is held asserted (>=1)
- TIMEOUT, 255, max idle cycles between valid samples before abort (>=1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset of this block
- start  in  1  one-cycle pulse: begin a run
- exp_we  in  1  write strobe for expected table
- exp_addr  in  log2(DEPTH)  expected-table write address
- exp_data  in  DATA_W  expected-table write data
- dout  in  DATA_W  processor output sample
- dout_vld  in  1  processor output sample valid
- dut_rst  out  1  active-high reset driven to processor
- busy  out  1  run in progress (RESET or RUN state)
- done  out  1  run finished (sticky until next start)
- pass  out  1  done with zero mismatches and no timeout
- timeout  out  1  run aborted on idle timeout
- err_cnt  out  log2(DEPTH)+1  mismatch count
- first_err_idx  out  log2(DEPTH)  index of first mismatch (0 if none)

Behaviour:
- Reset (rst=0 at edge) values: state IDLE, dut_rst=1, busy=0, done=0, pass=0, timeout=0, err_cnt=0, first_err_idx=0, sample index 0. The expected table is not cleared.
- Expected table: DEPTH x DATA_W register array, written when exp_we=1. Writes are accepted in any state; a write during RUN to an index not yet compared takes effect for that compare.
- FSM states: IDLE, RESET, RUN, DONE.
- IDLE: dut_rst=1. On start go to RESET; clear done, pass, timeout, err_cnt, first_err_idx, index, hold counter.
- RESET: dut_rst=1, busy=1. Hold counter counts RST_CYCLES cycles, then go to RUN; dut_rst=0 from the first RUN cycle.
- RUN: busy=1, dut_rst=0.
  - On dout_vld=1, compare dout with table[index].
  - On mismatch, err_cnt increments. If this is the first error, first_err_idx<=index.
  - index increments. When the sample at index DEPTH-1 is consumed, go to DONE next cycle (no wrap).
  - Idle counter resets on each valid sample and increments otherwise. When it reaches TIMEOUT, set timeout=1 and go to DONE.
  - A valid sample on the timeout cycle is compared and counted, and timeout still asserts.
- DONE: dut_rst=1, busy=0, done=1, pass=(err_cnt==0 && !timeout). On start, go to RESET (restart).
- start in RESET or RUN is ignored.
- dout_vld outside RUN is ignored.
- err_cnt saturates at DEPTH (cannot exceed it anyway).
- rst=0 mid-run: immediate return to reset values at that edge. The DUT is re-held in reset.
- All outputs are registered. Compare latency: err_cnt updates the cycle after the sample edge.

Optional Feature:
- Macro: RUN_MON_TRACE_EN.
- When defined:
  - adds a DEPTH x DATA_W capture RAM storing every valid dout at its index during RUN;
  - adds ports trace_addr (in, log2(DEPTH)) and trace_data (out, DATA_W, registered, 1-cycle read latency, reset 0).
- When undefined: no capture RAM and no trace ports; all other behaviour is identical.

Decomposition:
- Shared package (run_mon_pkg): state encoding constants (IDLE=0, RESET=1, RUN=2, DONE=3) and the clog2 function for index/count widths.
- One sub-module: run_mon_table, a generic DEPTH x DATA_W register file with one sync write port and one async read port. It is instantiated for the expected table and, under RUN_MON_TRACE_EN, for the trace RAM.

Test Plan:
- Load table 0x01..0x10, start, drive 16 matching samples with dout_vld every cycle -> dut_rst high exactly 5 cycles after start; done=1, pass=1, err_cnt=0 one cycle after the 16th sample.
- Same table; samples 3 and 9 are corrupted (0xFF) -> err_cnt=2, first_err_idx=3, pass=0, done=1.
- Start, send 4 matching samples, then hold dout_vld=0 -> timeout=1 and done=1 exactly 255 cycles after the 4th sample; pass=0, err_cnt=0.
- Mid-RUN (after 7 samples) drive rst=0 for one cycle -> next cycle all outputs are at reset values, dut_rst=1, state IDLE. A subsequent start runs a clean 16-sample pass.
- Pulse start during RUN and drive dout_vld=1 in IDLE -> no state change, no count change. Start in DONE restarts, with done cleared the next cycle.
- With RUN_MON_TRACE_EN: after a full run, read trace_addr 0..15 -> trace_data equals the driven samples, one cycle after each address.
